// File: rtl/bytecode_fetch_pkg.sv
// rtl/bytecode_fetch_pkg.sv - shared constants and FSM encoding for the bytecode fetch unit
package bytecode_fetch_pkg;

  localparam int BF_ADDR_SIZE = 16;

  typedef enum logic [1:0] {
    BF_IDLE  = 2'd0,
    BF_RUN   = 2'd1,
    BF_DRAIN = 2'd2
  } bf_state_e;

endpackage

// File: rtl/bytecode_fetch_byte_fifo.sv
// rtl/bytecode_fetch_byte_fifo.sv - DEPTH x 8 circular prefetch buffer with flush
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head_data,
  output logic [PTR_W:0]   count
);

  logic [7:0]     mem_q [DEPTH];
  logic [7:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // flush wins over a same-cycle push so stale returns never land after a redirect
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/bytecode_fetch.sv
// rtl/bytecode_fetch.sv - streams bytecode from instruction RAM into a prefetch FIFO for the JIT FSM
module bytecode_fetch
  import bytecode_fetch_pkg::*;
#(
  parameter int ADDR_W = BF_ADDR_SIZE,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] end_pc,
  input  logic              consume,
  output logic              iram_rd,
  output logic [ADDR_W-1:0] iram_adr,
  input  logic [7:0]        iram_q,
  output logic [7:0]        iram_data,
  output logic [ADDR_W-1:0] head_pc,
  output logic              waiting,
  output logic              done
);

  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(DEPTH);

  bf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] end_pc_q, end_pc_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic              epoch_q, epoch_d;
  logic              inflight_q, inflight_d;
  logic              inflight_epoch_q, inflight_epoch_d;
  logic              done_q, done_d;

  logic [PTR_W:0]    count;
  logic [PTR_W+1:0]  occupancy;
  logic              pop, push, issue;

  byte_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (start),
    .push      (push),
    .push_data (iram_q),
    .pop       (pop),
    .head_data (iram_data),
    .count     (count)
  );

  assign pop  = consume && (count != '0);
  // Only returns tagged with the current epoch belong to the active stream
  assign push = inflight_q && (inflight_epoch_q == epoch_q);

  // Credit check on post-pop occupancy including the read still in flight
  assign occupancy = (PTR_W+2)'(count) - (PTR_W+2)'(pop) + (PTR_W+2)'(inflight_q);
  assign issue     = (state_q == BF_RUN) && (occupancy < DEPTH_L) && (fetch_pc_q != end_pc_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = BF_RUN;
    end else begin
      case (state_q)
        BF_RUN:   if (fetch_pc_q == end_pc_q) state_d = BF_DRAIN;
        BF_DRAIN: if (count == '0 && !inflight_q) state_d = BF_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    end_pc_d         = end_pc_q;
    head_pc_d        = head_pc_q;
    epoch_d          = epoch_q;
    inflight_d       = issue;
    inflight_epoch_d = epoch_q;
    done_d           = done_q;
    if (start) begin
      fetch_pc_d = start_pc;
      end_pc_d   = end_pc;
      head_pc_d  = start_pc;
      epoch_d    = ~epoch_q;
      done_d     = 1'b0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      if (pop)   head_pc_d  = head_pc_q + ADDR_W'(1);
      if (state_q == BF_DRAIN && state_d == BF_IDLE) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q       <= '0;
      end_pc_q         <= '0;
      head_pc_q        <= '0;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      end_pc_q         <= end_pc_d;
      head_pc_q        <= head_pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      done_q           <= done_d;
    end
  end

  always_comb begin
    iram_rd  = issue;
    iram_adr = fetch_pc_q;
    head_pc  = head_pc_q;
    waiting  = (count == '0);
    done     = done_q;
  end

endmodule

// File: tb/tb_bytecode_fetch.sv
// tb/tb_bytecode_fetch.sv - directed self-checking bench for bytecode_fetch
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] start_pc;
  logic [15:0] end_pc;
  logic        consume;
  logic        iram_rd;
  logic [15:0] iram_adr;
  logic [7:0]  iram_q;
  logic [7:0]  iram_data;
  logic [15:0] head_pc;
  logic        waiting;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [15:0] issued[$];

  always #5 clk = ~clk;

  bytecode_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_pc  (start_pc),
    .end_pc    (end_pc),
    .consume   (consume),
    .iram_rd   (iram_rd),
    .iram_adr  (iram_adr),
    .iram_q    (iram_q),
    .iram_data (iram_data),
    .head_pc   (head_pc),
    .waiting   (waiting),
    .done      (done)
  );

  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    if (a >= 16'h0040 && a < 16'h0050) return 8'hA0 + 8'(a - 16'h0040);
    return 8'(a) + 8'h01;
  endfunction

  always @(posedge clk) begin
    if (iram_rd) iram_q <= ram_byte(iram_adr);
  end

  typedef struct {
    logic        start;
    logic        consume;
    logic        exp_wait;
    logic        exp_rd;
    logic [15:0] exp_adr;
    logic [7:0]  exp_data;
    logic [15:0] exp_head;
    logic        exp_done;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] spc, input logic [15:0] epc);
    start_pc = spc;
    end_pc   = epc;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic collect(input int n, input logic [7:0] d0, input logic [15:0] pc0, input string tag);
    int got = 0;
    int cyc = 0;
    issued.delete();
    while (got < n && cyc < 60) begin
      if (iram_rd) issued.push_back(iram_adr);
      if (!waiting) begin
        chk({tag, "_data"}, 32'(iram_data), 32'(8'(d0 + 8'(got))));
        chk({tag, "_head"}, 32'(head_pc), 32'(16'(pc0 + 16'(got))));
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int nrd;
    reset    = 1'b1;
    start    = 1'b0;
    start_pc = 16'h0;
    end_pc   = 16'h0;
    consume  = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 8'h00, 16'h0010, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0011, 8'h00, 16'h0010, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0012, 8'h11, 16'h0010, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0013, 8'h12, 16'h0011, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0014, 8'h13, 16'h0012, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0015, 8'h14, 16'h0013, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0016, 8'h15, 16'h0014, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0017, 8'h16, 16'h0015, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h17, 16'h0016, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h18, 16'h0017, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'h0018, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'h0018, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", 32'(iram_rd), 32'd0);
    chk("rst_adr", 32'(iram_adr), 32'd0);
    chk("rst_data", 32'(iram_data), 32'd0);
    chk("rst_head", 32'(head_pc), 32'd0);
    chk("rst_wait", 32'(waiting), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Basic stream with consume held from the start, including while waiting
    start_pc = 16'h0010;
    end_pc   = 16'h0018;
    for (int i = 0; i < 12; i++) begin
      start   = vecs[i].start;
      consume = vecs[i].consume;
      @(posedge clk); #1;
      chk($sformatf("v%0d_wait", i), 32'(waiting), 32'(vecs[i].exp_wait));
      chk($sformatf("v%0d_rd", i), 32'(iram_rd), 32'(vecs[i].exp_rd));
      if (vecs[i].exp_rd) chk($sformatf("v%0d_adr", i), 32'(iram_adr), 32'(vecs[i].exp_adr));
      if (!vecs[i].exp_wait) chk($sformatf("v%0d_data", i), 32'(iram_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_head", i), 32'(head_pc), 32'(vecs[i].exp_head));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
    end
    start = 1'b0;

    // Backpressure: exactly DEPTH reads, head held, then lossless resume
    consume = 1'b0;
    pulse_start(16'h0010, 16'h0018);
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      if (iram_rd) nrd++;
      @(posedge clk); #1;
    end
    chk("bp_reads", 32'(nrd), 32'd4);
    chk("bp_rd_idle", 32'(iram_rd), 32'd0);
    chk("bp_wait", 32'(waiting), 32'd0);
    chk("bp_data", 32'(iram_data), 32'h11);
    chk("bp_head", 32'(head_pc), 32'h10);
    consume = 1'b1;
    collect(8, 8'h11, 16'h0010, "bp");
    wait_done("bp");

    // Redirect with a read in flight: no stale bytes after the new start
    pulse_start(16'h0010, 16'h0018);
    collect(2, 8'h11, 16'h0010, "pre");
    pulse_start(16'h0040, 16'h0048);
    collect(4, 8'hA0, 16'h0040, "redir");

    // Address wrap through 0xFFFF
    pulse_start(16'hFFFE, 16'h0002);
    collect(4, 8'hFF, 16'hFFFE, "wrap");
    chk("wrap_nrd", 32'(issued.size()), 32'd4);
    if (issued.size() == 4) begin
      chk("wrap_a0", 32'(issued[0]), 32'hFFFE);
      chk("wrap_a1", 32'(issued[1]), 32'hFFFF);
      chk("wrap_a2", 32'(issued[2]), 32'h0000);
      chk("wrap_a3", 32'(issued[3]), 32'h0001);
    end
    wait_done("wrap");

    // Empty range: no reads, done two cycles after start
    pulse_start(16'h0020, 16'h0020);
    chk("empty_rd0", 32'(iram_rd), 32'd0);
    chk("empty_done0", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("empty_rd1", 32'(iram_rd), 32'd0);
    chk("empty_done1", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("empty_done2", 32'(done), 32'd1);

    // Asynchronous reset with three bytes buffered
    consume = 1'b0;
    pulse_start(16'h0010, 16'h0018);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_wait", 32'(waiting), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rd", 32'(iram_rd), 32'd0);
    chk("arst_adr", 32'(iram_adr), 32'd0);
    chk("arst_data", 32'(iram_data), 32'd0);
    chk("arst_head", 32'(head_pc), 32'd0);
    chk("arst_wait", 32'(waiting), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    nrd = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (iram_rd || !waiting) nrd++;
    end
    chk("post_rst_idle", 32'(nrd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bytecode_fetch.md
Name: bytecode_fetch

Overview:
Upstream feeder for the JIT translation state_machine. Streams JVM bytecode bytes from the synchronous instruction RAM into a small prefetch FIFO. Presents the head byte on iram_data, with a waiting flag, and pops it when the state machine consumes it. Supports start/redirect to a new bytecode PC and stops at a programmed end address.

Parameters:
ADDR_W, 16, byte address width of instruction RAM
DEPTH, 4, prefetch FIFO depth in bytes (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle pulse: begin fetching at start_pc (also redirect mid-run)
start_pc  input  ADDR_W  first bytecode address
end_pc  input  ADDR_W  exclusive end address, sampled with start
consume  input  1  state machine takes head byte this cycle
iram_rd  output  1  RAM read enable
iram_adr  output  ADDR_W  RAM read address
iram_q  input  8  RAM read data, valid exactly 1 cycle after iram_rd
iram_data  output  8  head byte to state_machine
head_pc  output  ADDR_W  address of the byte on iram_data
waiting  output  1  1 = no valid head byte (state machine must stall)
done  output  1  all bytes up to end_pc fetched and consumed

Behaviour:
- Reset values: iram_rd=0, iram_adr=0, iram_data=0, head_pc=0, waiting=1, done=0; FSM=IDLE; FIFO empty; in-flight=0; epoch=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE --start--> RUN.
  - RUN --(issue address == end_pc)--> DRAIN.
  - DRAIN --(FIFO empty and in-flight=0)--> IDLE with done=1.
  - start in any state --> RUN, and clears done.
- On start: fetch_pc<=start_pc, head_pc<=start_pc, end latched, FIFO flushed, epoch toggled. Any read issued before start whose data returns afterwards is discarded (tag mismatch on epoch).
- Issue rule (RUN only): iram_rd=1 when count + in_flight < DEPTH and fetch_pc != end_pc; iram_adr=fetch_pc; fetch_pc increments the following cycle. Credit counting uses the post-pop count, so a full FIFO with consume still issues.
- Return: data with matching epoch is written into the FIFO the cycle after issue. in_flight is 0 or 1 (1-cycle latency, 1 read/cycle).
- Output: iram_data = FIFO head (registered storage, combinational head mux). waiting = (count==0).
- Latency: start at cycle 0 -> read issued cycle 1 -> byte in FIFO, waiting=0 at cycle 2.
- Pop: consume && !waiting pops the head, head_pc+1. consume while waiting is ignored, no change.
- Simultaneous push and pop: count unchanged, both performed. Push to a full FIFO cannot occur (guaranteed by credit rule).
- Address arithmetic is modulo 2^ADDR_W: fetch_pc=all-ones wraps to 0. start_pc==end_pc means no reads; done=1 two cycles after start.
- done: held until next start or reset.
- Reset mid-operation: immediate return to reset values, and in-flight data is ignored.

Decomposition:
- me_consts.vh gains: `bf_addr_size (=ADDR_W default) and FSM encodings `BF_IDLE/`BF_RUN/`BF_DRAIN, shared with the state_machine bench.
- One sub-module, byte_fifo: DEPTH x 8 circular buffer with push, pop, flush, count, and simultaneous push/pop.
- The fetch FSM, credit counter and epoch logic stay in bytecode_fetch.

Test Plan:
- RAM model [0x10..0x17]=11..18, start_pc=0x10, end_pc=0x18, consume held 1 -> waiting drops at cycle 2; iram_data sequence 11..18, one per cycle; head_pc 0x10..0x17; done=1 after last pop.
- Same stream, consume=0 for 10 cycles -> exactly DEPTH=4 reads issued, then iram_rd=0; iram_data=11, waiting=0 held steady; releasing consume resumes without loss or duplication.
- Redirect: start_pc=0x10, consume 2 bytes, then start with start_pc=0x40 (RAM 0x40=0xA0..) while a read is in flight -> next bytes delivered are 0xA0,0xA1..., no stale byte from 0x12/0x13 appears.
- Wrap: start_pc=0xFFFE, end_pc=0x0002 -> reads at 0xFFFE,0xFFFF,0x0000,0x0001, then done=1.
- consume asserted while waiting (before first byte) -> ignored; first byte still 11 with head_pc=0x10. start_pc==end_pc=0x20 -> no iram_rd, done=1.
- Assert reset mid-stream with FIFO holding 3 bytes -> outputs return to reset values asynchronously; after release, waiting=1 and no reads occur until start.
